// File: rtl/rssi_multi.sv
`default_nettype none
// ============================================================================
// rssi_multi : per-channel leaky-average RSSI, overload density, peak hold,
//              hysteretic alarm and coherent snapshot readback.   Rev 1.0
// ============================================================================
module rssi_multi #(
    parameter int ADC_WIDTH = 12,
    parameter int NUM_CH    = 4,
    parameter int AVG_SHIFT = 10,
    parameter int OUT_WIDTH = 16,
    parameter int DECAY_LOG = 8
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          enable,
    input  logic                          sample_valid,
    input  logic [NUM_CH*ADC_WIDTH-1:0]   adc,
    input  logic [OUT_WIDTH-1:0]          thresh_hi,
    input  logic [OUT_WIDTH-1:0]          thresh_lo,
    input  logic                          snap_req,
    output logic [NUM_CH*OUT_WIDTH-1:0]   rssi,
    output logic [NUM_CH*OUT_WIDTH-1:0]   over_count,
    output logic [NUM_CH-1:0]             alarm,
    output logic [NUM_CH*OUT_WIDTH-1:0]   snap_rssi,
    output logic [NUM_CH*OUT_WIDTH-1:0]   snap_peak,
    output logic [NUM_CH*OUT_WIDTH-1:0]   snap_over,
    output logic                          snap_valid
);
    localparam int ACC_W = OUT_WIDTH + AVG_SHIFT;

    typedef enum logic [0:0] {SNAP_IDLE = 1'b0, SNAP_CAPTURE = 1'b1} snap_state_t;
    typedef enum logic [0:0] {ALM_CLEAR = 1'b0, ALM_SET = 1'b1} alarm_state_t;

    snap_state_t          snap_state_q, snap_state_d;
    logic [DECAY_LOG-1:0] decay_cnt_q, decay_cnt_d;
    logic                 clear_live;
    logic                 capture;
    logic                 decay_tick;

    // Shared control: snapshot sequencing and the common peak-decay timebase.
    always_comb begin
        clear_live   = !reset || !enable;
        capture      = (snap_state_q == SNAP_CAPTURE) && !clear_live;
        decay_tick   = sample_valid && (decay_cnt_q == '1);
        snap_valid   = capture;
        snap_state_d = SNAP_IDLE;
        decay_cnt_d  = decay_cnt_q;
        if (clear_live) begin
            decay_cnt_d = '0;
        end else begin
            if (snap_state_q == SNAP_IDLE && snap_req) begin
                snap_state_d = SNAP_CAPTURE;
            end
            if (sample_valid) begin
                decay_cnt_d = decay_cnt_q + DECAY_LOG'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            snap_state_q <= SNAP_IDLE;
            decay_cnt_q  <= '0;
        end else begin
            snap_state_q <= snap_state_d;
            decay_cnt_q  <= decay_cnt_d;
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [ADC_WIDTH-1:0] sample;
        logic [ADC_WIDTH-1:0] folded;
        logic                 over;
        logic [ACC_W-1:0]     abs_ext;
        logic [ACC_W-1:0]     over_inc;
        logic [OUT_WIDTH-1:0] peak_in;
        logic [OUT_WIDTH-1:0] rssi_live;
        logic [OUT_WIDTH-1:0] over_live;
        logic [ACC_W-1:0]     racc_q, racc_d;
        logic [ACC_W-1:0]     oacc_q, oacc_d;
        logic [OUT_WIDTH-1:0] peak_q, peak_d;
        alarm_state_t         alarm_q, alarm_d;
        logic [OUT_WIDTH-1:0] snap_rssi_q, snap_rssi_d;
        logic [OUT_WIDTH-1:0] snap_peak_q, snap_peak_d;
        logic [OUT_WIDTH-1:0] snap_over_q, snap_over_d;

        always_comb begin
            sample    = adc[c*ADC_WIDTH +: ADC_WIDTH];
            // One's-complement fold keeps the magnitude within ADC_WIDTH-1 bits.
            folded    = sample[ADC_WIDTH-1] ? ~sample : sample;
            over      = (sample == {1'b0, {(ADC_WIDTH-1){1'b1}}}) ||
                        (sample == {1'b1, {(ADC_WIDTH-1){1'b0}}});
            abs_ext   = {{(ACC_W-ADC_WIDTH){1'b0}}, folded};
            peak_in   = {{(OUT_WIDTH-ADC_WIDTH){1'b0}}, folded};
            over_inc  = over ? {{AVG_SHIFT{1'b0}}, {OUT_WIDTH{1'b1}}} : '0;
            rssi_live = racc_q[ACC_W-1 -: OUT_WIDTH];
            over_live = oacc_q[ACC_W-1 -: OUT_WIDTH];

            racc_d      = racc_q;
            oacc_d      = oacc_q;
            peak_d      = peak_q;
            alarm_d     = alarm_q;
            snap_rssi_d = snap_rssi_q;
            snap_peak_d = snap_peak_q;
            snap_over_d = snap_over_q;

            if (clear_live) begin
                racc_d  = '0;
                oacc_d  = '0;
                peak_d  = '0;
                alarm_d = ALM_CLEAR;
            end else begin
                if (sample_valid) begin
                    racc_d = racc_q + abs_ext - {{AVG_SHIFT{1'b0}}, rssi_live};
                    oacc_d = oacc_q + over_inc - {{AVG_SHIFT{1'b0}}, over_live};
                end
                // SET wins whenever rssi reaches thresh_hi, even if thresh_lo is above it.
                if (rssi_live >= thresh_hi) begin
                    alarm_d = ALM_SET;
                end else if (alarm_q == ALM_SET && rssi_live >= thresh_lo) begin
                    alarm_d = ALM_SET;
                end else begin
                    alarm_d = ALM_CLEAR;
                end
                if (capture) begin
                    snap_rssi_d = rssi_live;
                    snap_peak_d = peak_q;
                    snap_over_d = over_live;
                    peak_d      = sample_valid ? peak_in : '0;
                end else if (sample_valid) begin
                    if (peak_in > peak_q) begin
                        peak_d = peak_in;
                    end else if (decay_tick && peak_q != '0) begin
                        peak_d = peak_q - OUT_WIDTH'(1);
                    end
                end
            end
        end

        always_ff @(posedge clock) begin
            if (!reset) begin
                racc_q      <= '0;
                oacc_q      <= '0;
                peak_q      <= '0;
                alarm_q     <= ALM_CLEAR;
                snap_rssi_q <= '0;
                snap_peak_q <= '0;
                snap_over_q <= '0;
            end else begin
                racc_q      <= racc_d;
                oacc_q      <= oacc_d;
                peak_q      <= peak_d;
                alarm_q     <= alarm_d;
                snap_rssi_q <= snap_rssi_d;
                snap_peak_q <= snap_peak_d;
                snap_over_q <= snap_over_d;
            end
        end

        assign rssi      [c*OUT_WIDTH +: OUT_WIDTH] = rssi_live;
        assign over_count[c*OUT_WIDTH +: OUT_WIDTH] = over_live;
        assign alarm[c]                             = (alarm_q == ALM_SET);
        assign snap_rssi [c*OUT_WIDTH +: OUT_WIDTH] = snap_rssi_q;
        assign snap_peak [c*OUT_WIDTH +: OUT_WIDTH] = snap_peak_q;
        assign snap_over [c*OUT_WIDTH +: OUT_WIDTH] = snap_over_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_rssi_multi.sv
`default_nettype none
// ============================================================================
// tb_rssi_multi : randomized and directed bench for rssi_multi against an
//                 integer-arithmetic reference model.                Rev 1.0
// ============================================================================
module tb_rssi_multi;
    localparam int ADC_WIDTH = 12;
    localparam int NUM_CH    = 4;
    localparam int AVG_SHIFT = 10;
    localparam int OUT_WIDTH = 16;
    localparam int DECAY_LOG = 8;
    localparam int DECAY_PERIOD = 1 << DECAY_LOG;
    localparam int HALF         = 1 << (ADC_WIDTH - 1);
    localparam int OUT_MAX      = (1 << OUT_WIDTH) - 1;

    logic                        clock = 1'b0;
    logic                        reset = 1'b0;
    logic                        enable = 1'b0;
    logic                        sample_valid = 1'b0;
    logic [NUM_CH*ADC_WIDTH-1:0] adc = '0;
    logic [OUT_WIDTH-1:0]        thresh_hi = '1;
    logic [OUT_WIDTH-1:0]        thresh_lo = '0;
    logic                        snap_req = 1'b0;
    logic [NUM_CH*OUT_WIDTH-1:0] rssi, over_count, snap_rssi, snap_peak, snap_over;
    logic [NUM_CH-1:0]           alarm;
    logic                        snap_valid;

    rssi_multi #(
        .ADC_WIDTH(ADC_WIDTH), .NUM_CH(NUM_CH), .AVG_SHIFT(AVG_SHIFT),
        .OUT_WIDTH(OUT_WIDTH), .DECAY_LOG(DECAY_LOG)
    ) dut (
        .clock(clock), .reset(reset), .enable(enable), .sample_valid(sample_valid),
        .adc(adc), .thresh_hi(thresh_hi), .thresh_lo(thresh_lo), .snap_req(snap_req),
        .rssi(rssi), .over_count(over_count), .alarm(alarm),
        .snap_rssi(snap_rssi), .snap_peak(snap_peak), .snap_over(snap_over),
        .snap_valid(snap_valid)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 1'b0;

    // Reference model state, all plain integers.
    longint m_racc[NUM_CH];
    longint m_oacc[NUM_CH];
    int     m_peak[NUM_CH];
    bit     m_alarm[NUM_CH];
    int     m_snap_rssi[NUM_CH];
    int     m_snap_peak[NUM_CH];
    int     m_snap_over[NUM_CH];
    int     m_decay = 0;
    bit     m_capt  = 1'b0;

    function automatic int signed_val(input int raw);
        return (raw >= HALF) ? raw - 2 * HALF : raw;
    endfunction

    // ~x == -x-1 for negative two's-complement samples.
    function automatic int magnitude(input int raw);
        int v;
        v = signed_val(raw);
        return (v < 0) ? -v - 1 : v;
    endfunction

    function automatic bit overload(input int raw);
        int v;
        v = signed_val(raw);
        return (v == HALF - 1) || (v == -HALF);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
            if (n_errors >= 40) begin
                $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
                $finish;
            end
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic set_ch(input int c, input int val);
        adc[c*ADC_WIDTH +: ADC_WIDTH] = ADC_WIDTH'(val);
    endtask

    // Model advances on each rising edge from the inputs the DUT sees there.
    always @(posedge clock) begin
        bit cap, tick;
        int raw, mag, r, o;
        cap  = m_capt && reset && enable;
        tick = sample_valid && (m_decay == DECAY_PERIOD - 1);
        if (!reset || !enable) begin
            for (int c = 0; c < NUM_CH; c++) begin
                m_racc[c] = 0; m_oacc[c] = 0; m_peak[c] = 0; m_alarm[c] = 1'b0;
                if (!reset) begin
                    m_snap_rssi[c] = 0; m_snap_peak[c] = 0; m_snap_over[c] = 0;
                end
            end
            m_decay = 0;
            m_capt  = 1'b0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                raw = int'(adc[c*ADC_WIDTH +: ADC_WIDTH]);
                mag = magnitude(raw);
                r   = int'(m_racc[c] >> AVG_SHIFT);
                o   = int'(m_oacc[c] >> AVG_SHIFT);
                m_alarm[c] = (r >= int'(thresh_hi)) || (m_alarm[c] && r >= int'(thresh_lo));
                if (cap) begin
                    m_snap_rssi[c] = r;
                    m_snap_peak[c] = m_peak[c];
                    m_snap_over[c] = o;
                    m_peak[c]      = sample_valid ? mag : 0;
                end else if (sample_valid) begin
                    if (mag > m_peak[c]) m_peak[c] = mag;
                    else if (tick && m_peak[c] > 0) m_peak[c] = m_peak[c] - 1;
                end
                if (sample_valid) begin
                    m_racc[c] = m_racc[c] + mag - r;
                    m_oacc[c] = m_oacc[c] + (overload(raw) ? OUT_MAX : 0) - o;
                end
            end
            if (sample_valid) m_decay = (m_decay + 1) % DECAY_PERIOD;
            m_capt = !m_capt && snap_req;
        end
    end

    // Every-cycle comparison, half a period away from the active edge.
    always @(negedge clock) begin
        logic [NUM_CH*OUT_WIDTH-1:0] e_rssi, e_over, e_srssi, e_speak, e_sover;
        logic [NUM_CH-1:0]           e_alarm;
        if (chk_en) begin
            for (int c = 0; c < NUM_CH; c++) begin
                e_rssi [c*OUT_WIDTH +: OUT_WIDTH] = OUT_WIDTH'(m_racc[c] >> AVG_SHIFT);
                e_over [c*OUT_WIDTH +: OUT_WIDTH] = OUT_WIDTH'(m_oacc[c] >> AVG_SHIFT);
                e_srssi[c*OUT_WIDTH +: OUT_WIDTH] = OUT_WIDTH'(m_snap_rssi[c]);
                e_speak[c*OUT_WIDTH +: OUT_WIDTH] = OUT_WIDTH'(m_snap_peak[c]);
                e_sover[c*OUT_WIDTH +: OUT_WIDTH] = OUT_WIDTH'(m_snap_over[c]);
                e_alarm[c] = m_alarm[c];
            end
            check("rssi",       64'(rssi),       64'(e_rssi));
            check("over_count", 64'(over_count), 64'(e_over));
            check("alarm",      64'(alarm),      64'(e_alarm));
            check("snap_rssi",  64'(snap_rssi),  64'(e_srssi));
            check("snap_peak",  64'(snap_peak),  64'(e_speak));
            check("snap_over",  64'(snap_over),  64'(e_sover));
            check("snap_valid", 64'(snap_valid), 64'(m_capt && reset && enable));
        end
    end

    initial begin
        int pulses;
        cyc();
        chk_en = 1'b1;
        cyc();
        check("reset_rssi",       64'(rssi),       64'd0);
        check("reset_snap_peak",  64'(snap_peak),  64'd0);
        check("reset_alarm_sv",   64'({alarm, snap_valid}), 64'd0);

        // Settling: ch0=+100, ch1=+max, ch2=-100, ch3 alternating +max/-min.
        reset = 1'b1; enable = 1'b1; sample_valid = 1'b1;
        set_ch(0, 100); set_ch(1, 'h7FF); set_ch(2, 'hF9C);
        for (int i = 0; i < 20000; i++) begin
            set_ch(3, (i % 2 == 0) ? 'h7FF : 'h800);
            cyc();
        end
        check("settle_rssi_ch0", 64'(rssi[0*OUT_WIDTH +: OUT_WIDTH]), 64'd100);
        check("settle_rssi_ch1", 64'(rssi[1*OUT_WIDTH +: OUT_WIDTH]), 64'd2047);
        check("settle_rssi_ch2", 64'(rssi[2*OUT_WIDTH +: OUT_WIDTH]), 64'd99);
        check("settle_rssi_ch3", 64'(rssi[3*OUT_WIDTH +: OUT_WIDTH]), 64'd2047);
        check("settle_over_ch0", 64'(over_count[0*OUT_WIDTH +: OUT_WIDTH]), 64'd0);
        check("settle_over_ch1_high", 64'(over_count[1*OUT_WIDTH +: OUT_WIDTH] >= 16'd65534), 64'd1);
        check("settle_over_ch3_high", 64'(over_count[3*OUT_WIDTH +: OUT_WIDTH] >= 16'd65534), 64'd1);
        set_ch(1, 0); set_ch(3, 0);
        repeat (3000) cyc();

        // Alarm ramp with hysteresis on ch0.
        enable = 1'b0; cyc(); enable = 1'b1;
        thresh_hi = 16'd500; thresh_lo = 16'd400;
        adc = '0;
        set_ch(0, 600); repeat (3000) cyc();
        check("alarm_rise", 64'(alarm), 64'b0001);
        set_ch(0, 450); repeat (5000) cyc();
        check("alarm_hold", 64'(alarm), 64'b0001);
        set_ch(0, 350); repeat (5000) cyc();
        check("alarm_fall", 64'(alarm), 64'b0000);

        // Peak capture, then peak decay over 5 decay periods.
        enable = 1'b0; cyc(); enable = 1'b1;
        adc = '0; set_ch(0, 2000); sample_valid = 1'b1; cyc();
        sample_valid = 1'b0; adc = '0; snap_req = 1'b1; cyc();
        snap_req = 1'b0; cyc();
        check("peak_capture_2000", 64'(snap_peak[0 +: OUT_WIDTH]), 64'd2000);
        set_ch(0, 2000); sample_valid = 1'b1; cyc();
        adc = '0; repeat (DECAY_PERIOD * 5) cyc();
        sample_valid = 1'b0; snap_req = 1'b1; cyc();
        snap_req = 1'b0; cyc();
        check("peak_decay_1995", 64'(snap_peak[0 +: OUT_WIDTH]), 64'd1995);
        check("peak_other_ch",   64'(snap_peak[OUT_WIDTH +: OUT_WIDTH]), 64'd0);

        // Held request: every other cycle is accepted; nothing during reset.
        pulses = 0;
        snap_req = 1'b1;
        repeat (5) begin cyc(); pulses += int'(snap_valid); end
        snap_req = 1'b0; cyc(); pulses += int'(snap_valid);
        check("snap_back_to_back", 64'(pulses), 64'd3);
        pulses = 0;
        reset = 1'b0; snap_req = 1'b1;
        repeat (4) begin cyc(); pulses += int'(snap_valid); end
        reset = 1'b1; snap_req = 1'b0; cyc();
        pulses += int'(snap_valid);
        check("snap_in_reset", 64'(pulses), 64'd0);

        // Randomized traffic.
        for (int i = 0; i < 8000; i++) begin
            if (i % 1000 == 0) begin
                thresh_hi = OUT_WIDTH'($urandom_range(1500, 100));
                thresh_lo = OUT_WIDTH'($urandom_range(1500, 50));
            end
            reset        = ($urandom_range(2999, 0) != 0);
            enable       = ($urandom_range(1499, 0) != 0);
            sample_valid = ($urandom_range(3, 0) != 0);
            snap_req     = ($urandom_range(5, 0) == 0);
            for (int c = 0; c < NUM_CH; c++) begin
                case ($urandom_range(7, 0))
                    0:       set_ch(c, 'h7FF);
                    1:       set_ch(c, 'h800);
                    2:       set_ch(c, 0);
                    default: set_ch(c, int'($urandom_range(4095, 0)));
                endcase
            end
            cyc();
        end
        reset = 1'b1; enable = 1'b1; snap_req = 1'b0;
        repeat (4) cyc();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
